// File: rtl/max_pool_if.sv
// Pixel stream bundle for max_pool: raster-order input pixels and pooled output pixels.
// The master drives in_*, and the slave (the pooling block) drives out_*.
interface max_pool_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic                  out_last;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/max_pool.sv
// 2x2 stride-2 pooling over a raster pixel stream. Max pooling by default; define
// POOL_AVG_EN to switch to floor-average pooling.
module max_pool #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input logic       clock,
  input logic       reset,
  max_pool_if.slave bus
);

  localparam int unsigned ColW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned LbDepth = IMG_WIDTH / 2;
  localparam int unsigned LbIdxW  = (LbDepth > 1) ? $clog2(LbDepth) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned PairW   = DATA_WIDTH + 1;
`else
  localparam int unsigned PairW   = DATA_WIDTH;
`endif

  typedef enum logic {StEvenRow, StOddRow} row_phase_e;

`ifdef POOL_AVG_EN
  function automatic logic [PairW-1:0] combine_pair(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Two pair sums fit in DATA_WIDTH+2 bits, so the floor divide by 4 cannot overflow.
  function automatic logic [DATA_WIDTH-1:0] combine_quad(input logic [PairW-1:0] a,
                                                         input logic [PairW-1:0] b);
    logic [DATA_WIDTH+1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_WIDTH+1:2];
  endfunction
`else
  function automatic logic [PairW-1:0] combine_pair(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] combine_quad(input logic [PairW-1:0] a,
                                                         input logic [PairW-1:0] b);
    return (a > b) ? a : b;
  endfunction
`endif

  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  row_phase_e            phase_q, phase_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_pixel_q, out_pixel_d;

  logic [PairW-1:0]      linebuf [LbDepth];
  logic                  lb_we;
  logic [LbIdxW-1:0]     lb_idx;
  logic [PairW-1:0]      pair;
  logic [DATA_WIDTH-1:0] result;

  logic [ColW-1:0]       eff_col;
  logic [RowW-1:0]       eff_row;
  row_phase_e            eff_phase;

  // Start-of-frame overrides the counters for the pixel that carries it.
  always_comb begin
    eff_col   = col_q;
    eff_row   = row_q;
    eff_phase = phase_q;
    if (bus.in_valid && bus.in_sof) begin
      eff_col   = '0;
      eff_row   = '0;
      eff_phase = StEvenRow;
    end
  end

  assign lb_idx = LbIdxW'(eff_col >> 1);
  assign pair   = combine_pair(hold_q, bus.in_pixel);
  assign result = combine_quad(linebuf[lb_idx], pair);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_pixel_d = out_pixel_q;
    lb_we       = 1'b0;
    if (bus.in_valid) begin
      if (!eff_col[0]) begin
        hold_d = bus.in_pixel;
      end else if (eff_phase == StEvenRow) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_pixel_d = result;
        out_last_d  = (eff_row == RowW'(IMG_HEIGHT - 1)) && (eff_col == ColW'(IMG_WIDTH - 1));
      end

      if (eff_col == ColW'(IMG_WIDTH - 1)) begin
        col_d   = '0;
        row_d   = (eff_row == RowW'(IMG_HEIGHT - 1)) ? '0 : eff_row + RowW'(1);
        phase_d = (eff_phase == StEvenRow) ? StOddRow : StEvenRow;
      end else begin
        col_d   = eff_col + ColW'(1);
        row_d   = eff_row;
        phase_d = eff_phase;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      phase_q     <= StEvenRow;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Stale entries are always rewritten by an even row before an odd row reads them.
  always_ff @(posedge clock) begin
    if (lb_we) begin
      linebuf[lb_idx] <= pair;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_pixel = out_pixel_q;

endmodule
